ws2812_to_apa102: RTL and testbench

WS2812_TO_APA102 -- requirements
Module: ws2812_to_apa102

---
 rtl/ws2812_to_apa102_pkg.sv | 39 +++
 rtl/ws2812_rx.sv | 121 ++++++++++++
 rtl/ws2812_to_apa102.sv | 181 ++++++++++++++++++
 tb/tb_ws2812_to_apa102.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ws2812_to_apa102_pkg.sv
// ----------------------------------------------------------------------------
// ws2812_to_apa102_pkg
// Shared types and constants for the WS2812 -> APA102 bridge.
//   rx_state_t : one-wire receiver states
//   tx_state_t : APA102 transmitter states
//   entry_t    : queue entry {latch, grb[23:0]}
//   START_FRAME / END_FRAME / BRIGHT_HDR : fixed APA102 frame contents
//   pixel_word : reorders a WS2812 GRB triple into an APA102 LED frame
// ----------------------------------------------------------------------------
package ws2812_to_apa102_pkg;

  typedef enum logic [1:0] {
    RX_WAIT_LATCH,
    RX_LOW,
    RX_HIGH
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_PIXEL,
    TX_END
  } tx_state_t;

  typedef struct packed {
    logic        latch;
    logic [23:0] grb;
  } entry_t;

  localparam logic [31:0] START_FRAME = 32'h0000_0000;
  localparam logic [31:0] END_FRAME   = 32'hFFFF_FFFF;
  localparam logic [7:0]  BRIGHT_HDR  = 8'hFF;

  // APA102 LED frame is header, blue, green, red; WS2812 carries G, R, B.
  function automatic logic [31:0] pixel_word(input logic [23:0] grb);
    return {BRIGHT_HDR, grb[7:0], grb[23:16], grb[15:8]};
  endfunction

endpackage

// File: rtl/ws2812_rx.sv
// ----------------------------------------------------------------------------
// ws2812_rx
// Decodes the WS2812 one-wire stream into queue entries.
//   clk, rst       : clock, asynchronous active-high reset
//   i_ws           : raw asynchronous WS2812 data
//   o_push_valid   : one-cycle strobe, o_push_entry is valid
//   o_push_entry   : {latch=0, grb} for a pixel, {latch=1, 0} for a latch
// ----------------------------------------------------------------------------
module ws2812_rx
  import ws2812_to_apa102_pkg::*;
#(
  parameter int HI_THRESH = 30,
  parameter int RESET_LEN = 2500
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   i_ws,
  output logic   o_push_valid,
  output entry_t o_push_entry
);

  localparam int LOW_W  = $clog2(RESET_LEN + 1);
  localparam int HIGH_W = $clog2(HI_THRESH + 1);
  localparam logic [LOW_W-1:0]  LOW_MAX  = LOW_W'(RESET_LEN);
  localparam logic [LOW_W-1:0]  LOW_LAST = LOW_W'(RESET_LEN - 1);
  localparam logic [HIGH_W-1:0] HIGH_MAX = HIGH_W'(HI_THRESH);
  // The rising-edge cycle itself is high but the counter is cleared there,
  // so a pulse of N cycles leaves N-1 in the counter at the falling edge.
  localparam logic [HIGH_W-1:0] HIGH_ONE = HIGH_W'(HI_THRESH - 1);

  rx_state_t         r_state;
  rx_state_t         w_state_next;
  logic [1:0]        r_sync;
  logic              r_prev;
  logic [LOW_W-1:0]  r_low_cnt;
  logic [HIGH_W-1:0] r_high_cnt;
  logic [4:0]        r_bit_cnt;
  logic [23:0]       r_shift;
  logic              r_pix_seen;

  logic        w_din;
  logic        w_rise;
  logic        w_fall;
  logic        w_latch;
  logic        w_shift_en;
  logic        w_word_done;
  logic [23:0] w_shift_next;

  assign w_din        = r_sync[1];
  assign w_rise       = w_din & ~r_prev;
  assign w_fall       = ~w_din & r_prev;
  // Fires on the cycle the low run reaches RESET_LEN; saturation keeps it
  // from firing again until the line goes high.
  assign w_latch      = ~w_din && (r_low_cnt == LOW_LAST);
  assign w_shift_en   = (r_state == RX_HIGH) && w_fall;
  assign w_word_done  = w_shift_en && (r_bit_cnt == 5'd23);
  assign w_shift_next = {r_shift[22:0], (r_high_cnt >= HIGH_ONE)};

  // NOTE: state and counters use non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= RX_WAIT_LATCH;
      r_sync     <= '0;
      r_prev     <= 1'b0;
      r_low_cnt  <= '0;
      r_high_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_pix_seen <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_sync  <= {r_sync[0], i_ws};
      r_prev  <= w_din;

      if (w_din)                     r_low_cnt <= '0;
      else if (r_low_cnt != LOW_MAX) r_low_cnt <= r_low_cnt + 1'b1;

      if ((r_state == RX_LOW) && w_rise)
        r_high_cnt <= '0;
      else if ((r_state == RX_HIGH) && w_din && (r_high_cnt != HIGH_MAX))
        r_high_cnt <= r_high_cnt + 1'b1;

      if (w_shift_en) begin
        r_shift   <= w_shift_next;
        r_bit_cnt <= w_word_done ? 5'd0 : r_bit_cnt + 1'b1;
      end else if (w_latch) begin
        r_bit_cnt <= '0;
      end

      if (w_word_done)                         r_pix_seen <= 1'b1;
      else if ((r_state == RX_LOW) && w_latch) r_pix_seen <= 1'b0;
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      RX_WAIT_LATCH: if (w_latch) w_state_next = RX_LOW;
      RX_LOW:        if (w_rise)  w_state_next = RX_HIGH;
      RX_HIGH:       if (w_fall)  w_state_next = RX_LOW;
      default:                    w_state_next = RX_WAIT_LATCH;
    endcase
  end

  always_comb begin
    o_push_valid       = 1'b0;
    o_push_entry.latch = 1'b0;
    o_push_entry.grb   = w_shift_next;
    if (w_word_done) begin
      o_push_valid = 1'b1;
    end else if ((r_state == RX_LOW) && w_latch && r_pix_seen) begin
      o_push_valid       = 1'b1;
      o_push_entry.latch = 1'b1;
      o_push_entry.grb   = '0;
    end
  end

endmodule

// File: rtl/ws2812_to_apa102.sv
// ----------------------------------------------------------------------------
// ws2812_to_apa102
// Bridges a WS2812 one-wire pixel stream to an APA102 two-wire SPI strip.
//   clk, rst   : clock (rising edge), asynchronous active-high reset
//   ws2812_in  : asynchronous WS2812 data
//   apa102_sck : APA102 clock, idles low
//   apa102_sda : APA102 data, changes only while apa102_sck is low
//   busy       : transmitter active or queue non-empty
//   overflow   : sticky, a queue push was dropped
// ----------------------------------------------------------------------------
module ws2812_to_apa102
  import ws2812_to_apa102_pkg::*;
#(
  parameter int HI_THRESH  = 30,
  parameter int RESET_LEN  = 2500,
  parameter int SCK_HALF   = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic ws2812_in,
  output logic apa102_sck,
  output logic apa102_sda,
  output logic busy,
  output logic overflow
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;
  localparam int PH_W = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;
  localparam logic [CW-1:0]   DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(SCK_HALF - 1);

  // ---------------- receiver ----------------
  logic   w_push_valid;
  entry_t w_push_entry;

  ws2812_rx #(
    .HI_THRESH(HI_THRESH),
    .RESET_LEN(RESET_LEN)
  ) u_rx (
    .clk         (clk),
    .rst         (rst),
    .i_ws        (ws2812_in),
    .o_push_valid(w_push_valid),
    .o_push_entry(w_push_entry)
  );

  // ---------------- queue ----------------
  entry_t          r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            r_overflow;
  logic            w_full;
  logic            w_empty;
  logic            w_pop;
  logic            w_push_ok;
  entry_t          w_head;

  assign w_full    = (r_count == DEPTH_C);
  assign w_empty   = (r_count == '0);
  assign w_head    = r_mem[r_rd_ptr];
  // A pop in the same cycle frees the slot, so a full queue still accepts.
  assign w_push_ok = w_push_valid && (!w_full || w_pop);

  // NOTE: queue storage is deliberately not reset; the count and pointers
  // are, and no entry is ever read before it has been written.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= w_push_entry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_push_valid && !w_push_ok) r_overflow <= 1'b1;
    end
  end

  // ---------------- transmitter ----------------
  tx_state_t       r_tx_state;
  tx_state_t       w_tx_next;
  logic            r_in_strip;
  logic [31:0]     r_word;
  logic            r_sck;
  logic [PH_W-1:0] r_phase;
  logic [4:0]      r_bit_cnt;
  logic            w_load;
  logic [31:0]     w_load_word;
  logic            w_phase_end;
  logic            w_word_done;

  assign w_phase_end = (r_phase == PH_LAST);
  assign w_word_done = (r_tx_state != TX_IDLE) && r_sck && w_phase_end &&
                       (r_bit_cnt == 5'd31);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_state <= TX_IDLE;
      r_in_strip <= 1'b0;
      r_word     <= '0;
      r_sck      <= 1'b0;
      r_phase    <= '0;
      r_bit_cnt  <= '0;
    end else begin
      r_tx_state <= w_tx_next;
      // Loading the word puts its MSB on sda, so the first low phase starts
      // on the very next cycle.
      if (w_load) begin
        r_word    <= w_load_word;
        r_sck     <= 1'b0;
        r_phase   <= '0;
        r_bit_cnt <= '0;
      end else if (r_tx_state != TX_IDLE) begin
        if (!w_phase_end) begin
          r_phase <= r_phase + 1'b1;
        end else begin
          r_phase <= '0;
          if (!r_sck) begin
            r_sck <= 1'b1;
          end else begin
            r_sck <= 1'b0;
            if (!w_word_done) begin
              r_word    <= {r_word[30:0], 1'b0};
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end
      end
      if (w_word_done && (r_tx_state == TX_START))    r_in_strip <= 1'b1;
      else if (w_word_done && (r_tx_state == TX_END)) r_in_strip <= 1'b0;
    end
  end

  always_comb begin
    w_tx_next   = r_tx_state;
    w_pop       = 1'b0;
    w_load      = 1'b0;
    w_load_word = START_FRAME;
    unique case (r_tx_state)
      TX_IDLE: begin
        if (!w_empty) begin
          w_load = 1'b1;
          if (w_head.latch) begin
            w_pop       = 1'b1;
            w_load_word = END_FRAME;
            w_tx_next   = TX_END;
          end else if (!r_in_strip) begin
            // Pixel stays queued until the start frame has gone out.
            w_load_word = START_FRAME;
            w_tx_next   = TX_START;
          end else begin
            w_pop       = 1'b1;
            w_load_word = pixel_word(w_head.grb);
            w_tx_next   = TX_PIXEL;
          end
        end
      end
      default: if (w_word_done) w_tx_next = TX_IDLE;
    endcase
  end

  always_comb begin
    apa102_sck = r_sck;
    apa102_sda = r_word[31];
    busy       = (r_tx_state != TX_IDLE) || !w_empty;
    overflow   = r_overflow;
  end

endmodule

// File: tb/tb_ws2812_to_apa102.sv
`timescale 1ns/1ps
module tb_ws2812_to_apa102;

  localparam int LATCH_LOW = 3000;   // 60 us at 50 MHz
  localparam int DEPTH     = 4;

  logic clk = 1'b0;
  logic rst_a = 1'b1, rst_b = 1'b1;
  logic ws_a = 1'b0, ws_b = 1'b0;
  logic sck_a, sda_a, busy_a, ovf_a;
  logic sck_b, sda_b, busy_b, ovf_b;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard: expected 32-bit APA102 words per DUT, in output order.
  logic [31:0] exp_a[$];
  logic [31:0] exp_b[$];
  bit in_strip_a  = 1'b0;
  bit pix_since_a = 1'b0;

  int          edges [2];
  int          words [2];
  int          nbits [2];
  logic [31:0] shreg [2];

  ws2812_to_apa102 dut_a (
    .clk(clk), .rst(rst_a), .ws2812_in(ws_a),
    .apa102_sck(sck_a), .apa102_sda(sda_a), .busy(busy_a), .overflow(ovf_a)
  );

  ws2812_to_apa102 #(.SCK_HALF(200)) dut_b (
    .clk(clk), .rst(rst_b), .ws2812_in(ws_b),
    .apa102_sck(sck_b), .apa102_sda(sda_b), .busy(busy_b), .overflow(ovf_b)
  );

  always #10 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- stimulus ----------------
  task automatic hold(input int sel, input logic v, input int cycles);
    if (sel == 0) ws_a = v; else ws_b = v;
    repeat (cycles) @(negedge clk);
  endtask

  // 1 = 40 cycles high, 0 = 20 cycles high; periods alternate 62/63.
  task automatic send_bit(input int sel, input logic b, input logic odd);
    int hi;
    int per;
    hi  = b ? 40 : 20;
    per = odd ? 63 : 62;
    hold(sel, 1'b1, hi);
    hold(sel, 1'b0, per - hi);
  endtask

  task automatic send_pixel(input int sel, input logic [23:0] grb);
    for (int i = 23; i >= 0; i--) send_bit(sel, grb[i], i[0]);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] apa_pixel(input logic [23:0] grb);
    int g, r, b;
    g = int'(grb) / 65536;
    r = (int'(grb) / 256) % 256;
    b = int'(grb) % 256;
    return 32'hFF00_0000 + 32'(b * 65536 + g * 256 + r);
  endfunction

  // A strip opens with a start frame before its first pixel.
  task automatic model_pixel_a(input logic [23:0] grb);
    if (!in_strip_a) begin
      exp_a.push_back(32'h0000_0000);
      in_strip_a = 1'b1;
    end
    exp_a.push_back(apa_pixel(grb));
    pix_since_a = 1'b1;
  endtask

  // A latch closes the strip only if pixels arrived since the last one.
  task automatic model_latch_a();
    if (pix_since_a) begin
      exp_a.push_back(32'hFFFF_FFFF);
      in_strip_a  = 1'b0;
      pix_since_a = 1'b0;
    end
  endtask

  task automatic pixel_a(input logic [23:0] grb);
    model_pixel_a(grb);
    send_pixel(0, grb);
  endtask

  task automatic latch_a();
    model_latch_a();
    hold(0, 1'b0, LATCH_LOW);
  endtask

  task automatic wait_idle(input int sel, input int budget, input string name);
    int i;
    i = 0;
    while (i < budget &&
           !(((sel == 0) ? exp_a.size() : exp_b.size()) == 0 &&
             ((sel == 0) ? busy_a : busy_b) == 1'b0)) begin
      @(negedge clk);
      i++;
    end
    check({name, "_pending"}, (sel == 0) ? exp_a.size() : exp_b.size(), 0);
    check({name, "_busy"}, (sel == 0) ? busy_a : busy_b, 1'b0);
  endtask

  // ---------------- monitor ----------------
  // Collects sda on each SCK rising edge (seen on the falling clk edge) and
  // compares every completed 32-bit word against the scoreboard head.
  task automatic monitor(input int sel);
    logic prev;
    logic s, d, r;
    logic [31:0] e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      s = (sel == 0) ? sck_a : sck_b;
      d = (sel == 0) ? sda_a : sda_b;
      r = (sel == 0) ? rst_a : rst_b;
      if (r) begin
        nbits[sel] = 0;
        prev = 1'b0;
      end else begin
        if (s && !prev) begin
          edges[sel]++;
          shreg[sel] = {shreg[sel][30:0], d};
          nbits[sel]++;
          if (nbits[sel] == 32) begin
            nbits[sel] = 0;
            words[sel]++;
            if (((sel == 0) ? exp_a.size() : exp_b.size()) == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL unexpected_word dut%0d: got %h, expected none", sel, shreg[sel]);
            end else begin
              e = (sel == 0) ? exp_a.pop_front() : exp_b.pop_front();
              check($sformatf("word%0d_dut%0d", words[sel], sel), shreg[sel], e);
            end
          end
        end
        prev = s;
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  // ---------------- test flow ----------------
  task automatic flow_a();
    int e0, w0, i;
    logic [23:0] px;
    repeat (4) @(negedge clk);
    check("rst_sck", sck_a, 1'b0);
    check("rst_sda", sda_a, 1'b0);
    check("rst_busy", busy_a, 1'b0);
    check("rst_ovf", ovf_a, 1'b0);
    rst_a = 1'b0;

    // Pulses before any long low are ignored.
    send_pixel(0, 24'(($urandom)));
    send_pixel(0, 24'h5A_C3_0F);
    hold(0, 1'b0, 200);
    check("pre_latch_edges", edges[0], 0);
    check("pre_latch_busy", busy_a, 1'b0);
    hold(0, 1'b0, LATCH_LOW);
    check("first_latch_edges", edges[0], 0);

    // Single pixel strip.
    pixel_a(24'h11_22_33);
    latch_a();
    wait_idle(0, 5000, "single");

    // Three pixels in one strip.
    pixel_a(24'hFF_00_00);
    pixel_a(24'h00_FF_00);
    pixel_a(24'h00_00_FF);
    latch_a();
    wait_idle(0, 5000, "three");
    check("three_ovf", ovf_a, 1'b0);

    // Partial bits are dropped by the latch.
    for (int k = 0; k < 10; k++) send_bit(0, k[0], k[0]);
    latch_a();
    pixel_a(24'hAA_AA_AA);
    latch_a();
    wait_idle(0, 5000, "partial");

    // Random strips.
    for (int s = 0; s < 3; s++) begin
      for (int p = 0; p < int'($urandom_range(2, 1)); p++) pixel_a(24'($urandom));
      latch_a();
    end
    wait_idle(0, 5000, "random");

    // Reset in the middle of a pixel word.
    w0 = words[0];
    px = 24'($urandom);
    pixel_a(px);
    i = 0;
    while (i < 20000 && !(words[0] == w0 + 1 && nbits[0] >= 10)) begin
      @(negedge clk);
      i++;
    end
    check("reach_bit10", (i < 20000), 1'b1);
    rst_a = 1'b1;
    #1;
    check("midrst_sck", sck_a, 1'b0);
    check("midrst_sda", sda_a, 1'b0);
    check("midrst_busy", busy_a, 1'b0);
    exp_a.delete();
    in_strip_a  = 1'b0;
    pix_since_a = 1'b0;
    e0 = edges[0];
    repeat (5) @(negedge clk);
    rst_a = 1'b0;
    hold(0, 1'b0, LATCH_LOW);
    check("post_rst_quiet", edges[0] - e0, 0);
    pixel_a(24'h12_34_56);
    latch_a();
    wait_idle(0, 5000, "after_rst");
  endtask

  // SCK_HALF=200: the start frame lasts 12800 cycles, longer than six pixels
  // plus the following latch, so nothing drains during the burst. The first
  // DEPTH pixels are accepted; the rest and the latch are dropped.
  task automatic flow_b();
    logic [23:0] px;
    repeat (4) @(negedge clk);
    rst_b = 1'b0;
    hold(1, 1'b0, LATCH_LOW);
    exp_b.push_back(32'h0000_0000);
    for (int p = 0; p < 6; p++) begin
      px = 24'($urandom);
      if (p < DEPTH) exp_b.push_back(apa_pixel(px));
      send_pixel(1, px);
    end
    hold(1, 1'b0, LATCH_LOW);
    check("burst_ovf", ovf_b, 1'b1);
    wait_idle(1, 70000, "burst");
    check("burst_ovf_sticky", ovf_b, 1'b1);
  endtask

  initial begin
    fork
      flow_a();
      flow_b();
    join
    repeat (10) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
